// File: rtl/nem_relay_pkg.sv
// Shared definitions for NEM relay drivers: relay sequencing states and default
// break/make dwell times.
package nem_relay_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    BREAK  = 2'd1,
    MAKE   = 2'd2,
    STABLE = 2'd3
  } relay_state_t;

  localparam int NEM_BREAK_CYC = 4;
  localparam int NEM_MAKE_CYC  = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nem_relay_dwell_cnt.sv
// Loadable down-counter that times relay break/make dwell periods.
// Saturates at zero instead of wrapping.
module nem_relay_dwell_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make select controller for a NEM one-hot inverting mux, plus the
// re-inverting, settle-qualified output register for the mux's ZN lines.
module nem_ohmux_sel_ctrl
  import nem_relay_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int WIDTH     = 8,
  parameter int BREAK_CYC = NEM_BREAK_CYC,
  parameter int MAKE_CYC  = NEM_MAKE_CYC,
  localparam int SW       = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel_valid,
  output logic             sel_ready,
  input  logic [SW-1:0]    sel_req,
  input  logic             sel_off,
  output logic [N_IN-1:0]  S,
  output logic [SW-1:0]    cur_sel,
  output logic             settled,
  input  logic [WIDTH-1:0] zn_in,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  localparam int CW = $clog2(max_int(BREAK_CYC, MAKE_CYC) + 1);

  relay_state_t    state, state_n;
  logic [N_IN-1:0] s_n;
  logic [SW-1:0]   cur_n;
  logic            settled_n;
  logic [SW-1:0]   tgt, tgt_n;
  logic            tgt_off, tgt_off_n;

  logic            cnt_load;
  logic [CW-1:0]   cnt_val;
  logic            cnt_dec;
  logic            cnt_zero;

  logic            accept;
  logic            req_off;

  function automatic logic [N_IN-1:0] onehot(input logic [SW-1:0] idx);
    return N_IN'(1) << idx;
  endfunction

  assign sel_ready = (state == OFF) || (state == STABLE);
  assign accept    = sel_valid && sel_ready;
  // Out-of-range indices have no relay to close, so they behave like a disconnect.
  assign req_off   = sel_off || ({1'b0, sel_req} >= (SW+1)'(N_IN));

  nem_relay_dwell_cnt #(
    .CW(CW)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= OFF;
      S       <= '0;
      cur_sel <= '0;
      settled <= 1'b0;
      tgt     <= '0;
      tgt_off <= 1'b0;
    end else begin
      state   <= state_n;
      S       <= s_n;
      cur_sel <= cur_n;
      settled <= settled_n;
      tgt     <= tgt_n;
      tgt_off <= tgt_off_n;
    end
  end

  always_comb begin
    state_n   = state;
    s_n       = S;
    cur_n     = cur_sel;
    settled_n = settled;
    tgt_n     = tgt;
    tgt_off_n = tgt_off;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;

    case (state)
      OFF: begin
        // Relays are already open here, so the break dwell can be skipped.
        if (accept && !req_off) begin
          s_n      = onehot(sel_req);
          cur_n    = sel_req;
          cnt_load = 1'b1;
          cnt_val  = CW'(MAKE_CYC - 1);
          state_n  = MAKE;
        end
      end

      BREAK: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (tgt_off) begin
          cur_n   = '0;
          state_n = OFF;
        end else begin
          s_n      = onehot(tgt);
          cur_n    = tgt;
          cnt_load = 1'b1;
          cnt_val  = CW'(MAKE_CYC - 1);
          state_n  = MAKE;
        end
      end

      MAKE: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          settled_n = 1'b1;
          state_n   = STABLE;
        end
      end

      STABLE: begin
        // Re-selecting the made input is a no-op so the closed relay never glitches.
        if (accept && (req_off || (sel_req != cur_sel))) begin
          s_n       = '0;
          settled_n = 1'b0;
          tgt_n     = sel_req;
          tgt_off_n = req_off;
          cnt_load  = 1'b1;
          cnt_val   = CW'(BREAK_CYC - 1);
          state_n   = BREAK;
        end
      end

      default: begin
        s_n       = '0;
        cur_n     = '0;
        settled_n = 1'b0;
        state_n   = OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= settled ? ~zn_in : '0;
      dout_valid <= settled;
    end
  end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Scoreboard bench for nem_ohmux_sel_ctrl: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them and checks relay safety.
module tb_nem_ohmux_sel_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sel_valid = 1'b0;
  logic       sel_ready;
  logic [0:0] sel_req = '0;
  logic       sel_off = 1'b0;
  logic [1:0] s;
  logic [0:0] cur_sel;
  logic       settled;
  logic [7:0] zn_in = 8'h5A;
  logic [7:0] dout;
  logic       dout_valid;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;
  logic [1:0] prev_s = '0;

  typedef struct {
    int    cyc;
    string name;
    int    s;
    int    cur;
    int    st;
    int    rdy;
    int    dv;
    int    dout;
  } exp_t;

  exp_t exp_q[$];

  nem_ohmux_sel_ctrl #(
    .N_IN(2),
    .WIDTH(8),
    .BREAK_CYC(4),
    .MAKE_CYC(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_req    (sel_req),
    .sel_off    (sel_off),
    .S          (s),
    .cur_sel    (cur_sel),
    .settled    (settled),
    .zn_in      (zn_in),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void expect_row(input int c, input string name, input int s_e,
                                     input int cur_e, input int st_e, input int rdy_e,
                                     input int dv_e, input int dout_e);
    exp_t e;
    e.cyc = c; e.name = name; e.s = s_e; e.cur = cur_e;
    e.st = st_e; e.rdy = rdy_e; e.dv = dv_e; e.dout = dout_e;
    exp_q.push_back(e);
  endfunction

  // Monitor: every cycle the controller presents a full output snapshot.
  always @(negedge clk) begin
    if (!done) begin
      check_output("relay_safe",
                   int'(($countones(s) <= 1) && !((prev_s != 0) && (s != 0) && (prev_s != s))),
                   1);
      prev_s = s;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          check_output({e.name, "_missed"}, cyc, e.cyc);
        end else begin
          check_output({e.name, ".S"}, int'(s), e.s);
          check_output({e.name, ".cur_sel"}, int'(cur_sel), e.cur);
          check_output({e.name, ".settled"}, int'(settled), e.st);
          check_output({e.name, ".sel_ready"}, int'(sel_ready), e.rdy);
          check_output({e.name, ".dout_valid"}, int'(dout_valid), e.dv);
          check_output({e.name, ".dout"}, int'(dout), e.dout);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic apply_stimulus(input logic v, input logic [0:0] req, input logic off);
    sel_valid = v;
    sel_req   = req;
    sel_off   = off;
  endtask

  initial begin
    int t0, t1, t2, t3, t4, t5;

    step();
    step();
    expect_row(cyc, "reset", 0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    wait_until(5);
    expect_row(cyc, "idle", 0, 0, 0, 1, 0, 0);

    // From OFF straight into MAKE
    t0 = cyc;
    zn_in = 8'hA5;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_row(t0 + 1,  "off_to1_make",   2, 1, 0, 0, 0, 0);
    expect_row(t0 + 8,  "off_to1_late",   2, 1, 0, 0, 0, 0);
    expect_row(t0 + 9,  "off_to1_settle", 2, 1, 1, 1, 0, 0);
    expect_row(t0 + 10, "off_to1_dout",   2, 1, 1, 1, 1, 8'h5A);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);

    // Switch 1 -> 0 with break-before-make
    t1 = t0 + 12;
    wait_until(t1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    expect_row(t1 + 1,  "sw_break0",  0, 1, 0, 0, 1, 8'h5A);
    expect_row(t1 + 2,  "sw_break1",  0, 1, 0, 0, 0, 0);
    expect_row(t1 + 4,  "sw_breakend", 0, 1, 0, 0, 0, 0);
    expect_row(t1 + 5,  "sw_make",    1, 0, 0, 0, 0, 0);
    expect_row(t1 + 12, "sw_makeend", 1, 0, 0, 0, 0, 0);
    expect_row(t1 + 13, "sw_settle",  1, 0, 1, 1, 0, 0);
    expect_row(t1 + 14, "sw_dout",    1, 0, 1, 1, 1, 8'hC3);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    zn_in = 8'h3C;

    // Re-select current input: no glitch
    t2 = t1 + 16;
    wait_until(t2);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    expect_row(t2 + 1, "same_sel0", 1, 0, 1, 1, 1, 8'hC3);
    expect_row(t2 + 2, "same_sel1", 1, 0, 1, 1, 1, 8'hC3);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);

    // Disconnect; sel_off overrides sel_req
    t3 = t2 + 3;
    wait_until(t3);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    expect_row(t3 + 1, "off_break0", 0, 0, 0, 0, 1, 8'hC3);
    expect_row(t3 + 2, "off_break1", 0, 0, 0, 0, 0, 0);
    expect_row(t3 + 4, "off_break3", 0, 0, 0, 0, 0, 0);
    expect_row(t3 + 5, "off_done",   0, 0, 0, 1, 0, 0);
    expect_row(t3 + 6, "off_idle",   0, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);

    // Request held through MAKE, then reset mid-BREAK
    t4 = t3 + 7;
    wait_until(t4);
    zn_in = 8'hA5;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_row(t4 + 1,  "hold_make",   2, 1, 0, 0, 0, 0);
    expect_row(t4 + 5,  "hold_stall",  2, 1, 0, 0, 0, 0);
    expect_row(t4 + 9,  "hold_stable", 2, 1, 1, 1, 0, 0);
    expect_row(t4 + 10, "hold_accept", 0, 1, 0, 0, 1, 8'h5A);
    expect_row(t4 + 11, "hold_break",  0, 1, 0, 0, 0, 0);
    expect_row(t4 + 12, "mid_reset",   0, 0, 0, 1, 0, 0);
    expect_row(t4 + 14, "post_reset",  0, 0, 0, 1, 0, 0);
    step();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    wait_until(t4 + 10);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Fresh request after reset behaves like a cold start
    t5 = t4 + 14;
    wait_until(t5);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    expect_row(t5 + 1,  "again_make",   2, 1, 0, 0, 0, 0);
    expect_row(t5 + 9,  "again_settle", 2, 1, 1, 1, 0, 0);
    expect_row(t5 + 10, "again_dout",   2, 1, 1, 1, 1, 8'h5A);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0);
    wait_until(t5 + 12);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
